// File: rtl/crc_stream_engine.sv
// Streaming CRC generator/checker: folds BITS_PER_CYC message bits per clock
// through an MSB-first LFSR and presents the finalised CRC on a held valid/ready port.
module crc_stream_engine #(
  parameter int          CRC_W        = 32,
  parameter int          DATA_W       = 32,
  parameter logic [31:0] POLY         = 32'h04C11DB7,
  parameter logic [31:0] INIT         = 32'hFFFFFFFF,
  parameter logic [31:0] XOR_OUT      = 32'hFFFFFFFF,
  parameter bit          REFIN        = 1'b1,
  parameter bit          REFOUT       = 1'b1,
  parameter int          BITS_PER_CYC = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_first,
  input  logic              in_last,
  output logic              in_ready,
  output logic [CRC_W-1:0]  crc_out,
  output logic              crc_valid,
  input  logic              crc_ready,
  output logic              busy
);

  localparam int NCYC  = DATA_W / BITS_PER_CYC;
  localparam int CNT_W = (NCYC > 1) ? $clog2(NCYC) : 1;

  localparam logic [CRC_W-1:0] POLY_C = POLY[CRC_W-1:0];
  localparam logic [CRC_W-1:0] INIT_C = INIT[CRC_W-1:0];
  localparam logic [CRC_W-1:0] XOR_C  = XOR_OUT[CRC_W-1:0];
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCYC - 1);

  if ((DATA_W % 8) != 0 || (DATA_W % BITS_PER_CYC) != 0) begin : g_bad_width
    $error("crc_stream_engine: DATA_W must be a multiple of 8 and of BITS_PER_CYC");
  end
  if (CRC_W < 8 || CRC_W > 32) begin : g_bad_crc_w
    $error("crc_stream_engine: CRC_W must lie in 8..32");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  state_t             state_r;
  logic [CRC_W-1:0]   crc_r;
  logic [DATA_W-1:0]  beat_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               last_r;
  logic               in_ready_r;
  logic               crc_valid_r;
  logic [CRC_W-1:0]   crc_out_r;
  logic               busy_r;

  logic [CRC_W-1:0]   fold_s;
  logic [DATA_W-1:0]  beat_next_s;

  // Rearrange a beat so bit k is the k-th bit to enter the LFSR (bytes in order,
  // each byte LSB first when REFIN, MSB first otherwise).
  function automatic logic [DATA_W-1:0] order_bits(input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] s;
    s = '0;
    for (int k = 0; k < DATA_W; k++) begin
      if (REFIN) begin
        s[k] = d[k];
      end else begin
        s[k] = d[(k / 8) * 8 + 7 - (k % 8)];
      end
    end
    return s;
  endfunction

  function automatic logic [CRC_W-1:0] fold(input logic [CRC_W-1:0]        r,
                                            input logic [BITS_PER_CYC-1:0] b);
    logic [CRC_W-1:0] v;
    logic             fb;
    v = r;
    for (int i = 0; i < BITS_PER_CYC; i++) begin
      fb = v[CRC_W-1] ^ b[i];
      v  = {v[CRC_W-2:0], 1'b0} ^ (fb ? POLY_C : {CRC_W{1'b0}});
    end
    return v;
  endfunction

  function automatic logic [CRC_W-1:0] finalize(input logic [CRC_W-1:0] r);
    logic [CRC_W-1:0] o;
    for (int i = 0; i < CRC_W; i++) begin
      o[i] = REFOUT ? r[CRC_W-1-i] : r[i];
    end
    return o ^ XOR_C;
  endfunction

  assign fold_s      = fold(crc_r, beat_r[BITS_PER_CYC-1:0]);
  assign beat_next_s = beat_r >> BITS_PER_CYC;

  // Control FSM, CRC datapath and registered handshake outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      crc_r       <= INIT_C;
      beat_r      <= '0;
      cnt_r       <= '0;
      last_r      <= 1'b0;
      in_ready_r  <= 1'b1;
      crc_valid_r <= 1'b0;
      crc_out_r   <= '0;
      busy_r      <= 1'b0;
    end else if (clr) begin
      state_r     <= ST_IDLE;
      crc_r       <= INIT_C;
      beat_r      <= '0;
      cnt_r       <= '0;
      last_r      <= 1'b0;
      in_ready_r  <= 1'b1;
      crc_valid_r <= 1'b0;
      crc_out_r   <= '0;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            beat_r     <= order_bits(in_data);
            last_r     <= in_last;
            crc_r      <= in_first ? INIT_C : crc_r;
            cnt_r      <= '0;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b1;
            state_r    <= ST_SHIFT;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          crc_r  <= fold_s;
          beat_r <= beat_next_s;
          if (cnt_r == LAST_CNT) begin
            cnt_r <= '0;
            if (last_r) begin
              crc_out_r   <= finalize(fold_s);
              crc_valid_r <= 1'b1;
              state_r     <= ST_HOLD;
            end else begin
              in_ready_r <= 1'b1;
              state_r    <= ST_IDLE;
            end
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        ST_HOLD: begin
          // The register restarts from INIT so a following message without
          // in_first still computes a stand-alone CRC.
          if (crc_ready) begin
            crc_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
            crc_r       <= INIT_C;
            state_r     <= ST_IDLE;
          end else begin
            state_r <= ST_HOLD;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          crc_r       <= INIT_C;
          cnt_r       <= '0;
          in_ready_r  <= 1'b1;
          crc_valid_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign crc_valid = crc_valid_r;
  assign crc_out   = crc_out_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_crc_stream_engine.sv
// Scoreboard bench for crc_stream_engine: six parameterisations driven by directed
// messages; a forked monitor pops expected CRCs on every result handshake.
module tb_crc_stream_engine;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [5:0]  clr, in_valid, in_first, in_last, crc_ready;
  logic [31:0] in_data [6];
  wire  [5:0]  in_ready, crc_valid, busy;
  wire  [31:0] crc_o [6];
  wire  [15:0] crc_c16;
  assign crc_o[2] = {16'h0000, crc_c16};

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q [6][$];

  // 0: CRC-32 on bytes
  crc_stream_engine #(.DATA_W(8)) u_a (
    .clk(clk), .rst(rst), .clr(clr[0]), .in_data(in_data[0][7:0]), .in_valid(in_valid[0]),
    .in_first(in_first[0]), .in_last(in_last[0]), .in_ready(in_ready[0]), .crc_out(crc_o[0]),
    .crc_valid(crc_valid[0]), .crc_ready(crc_ready[0]), .busy(busy[0]));
  // 1: CRC-32/MPEG-2
  crc_stream_engine #(.DATA_W(8), .REFIN(1'b0), .REFOUT(1'b0), .XOR_OUT(32'h0)) u_b (
    .clk(clk), .rst(rst), .clr(clr[1]), .in_data(in_data[1][7:0]), .in_valid(in_valid[1]),
    .in_first(in_first[1]), .in_last(in_last[1]), .in_ready(in_ready[1]), .crc_out(crc_o[1]),
    .crc_valid(crc_valid[1]), .crc_ready(crc_ready[1]), .busy(busy[1]));
  // 2: CRC-16/CCITT-FALSE
  crc_stream_engine #(.CRC_W(16), .DATA_W(8), .POLY(32'h1021), .INIT(32'hFFFF),
                      .REFIN(1'b0), .REFOUT(1'b0), .XOR_OUT(32'h0)) u_c (
    .clk(clk), .rst(rst), .clr(clr[2]), .in_data(in_data[2][7:0]), .in_valid(in_valid[2]),
    .in_first(in_first[2]), .in_last(in_last[2]), .in_ready(in_ready[2]), .crc_out(crc_c16),
    .crc_valid(crc_valid[2]), .crc_ready(crc_ready[2]), .busy(busy[2]));
  // 3..5: CRC-32 on 32-bit beats at 1, 8 and 32 bits per clock
  crc_stream_engine #(.DATA_W(32), .BITS_PER_CYC(1)) u_d1 (
    .clk(clk), .rst(rst), .clr(clr[3]), .in_data(in_data[3]), .in_valid(in_valid[3]),
    .in_first(in_first[3]), .in_last(in_last[3]), .in_ready(in_ready[3]), .crc_out(crc_o[3]),
    .crc_valid(crc_valid[3]), .crc_ready(crc_ready[3]), .busy(busy[3]));
  crc_stream_engine #(.DATA_W(32), .BITS_PER_CYC(8)) u_d8 (
    .clk(clk), .rst(rst), .clr(clr[4]), .in_data(in_data[4]), .in_valid(in_valid[4]),
    .in_first(in_first[4]), .in_last(in_last[4]), .in_ready(in_ready[4]), .crc_out(crc_o[4]),
    .crc_valid(crc_valid[4]), .crc_ready(crc_ready[4]), .busy(busy[4]));
  crc_stream_engine #(.DATA_W(32), .BITS_PER_CYC(32)) u_d32 (
    .clk(clk), .rst(rst), .clr(clr[5]), .in_data(in_data[5]), .in_valid(in_valid[5]),
    .in_first(in_first[5]), .in_last(in_last[5]), .in_ready(in_ready[5]), .crc_out(crc_o[5]),
    .crc_valid(crc_valid[5]), .crc_ready(crc_ready[5]), .busy(busy[5]));

  task automatic check(input string name, input int inst, input logic [31:0] act,
                       input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s inst=%0d got=%h required=%h", name, inst, act, req);
    end
  endtask

  // Reflected byte-wise CRC-32 reference (0xEDB88320 form).
  function automatic logic [31:0] crc32_ref(input logic [7:0] b [$]);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (b[i]) begin
      c = c ^ {24'h0, b[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic monitor();
    logic [31:0] e;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 6; i++) begin
        if (rst && crc_valid[i] && crc_ready[i]) begin
          if (exp_q[i].size() == 0) begin
            check("spurious_result", i, 32'h1, 32'h0);
          end else begin
            e = exp_q[i].pop_front();
            check("crc_out", i, crc_o[i], e);
          end
        end
      end
    end
  endtask

  task automatic send_beat(input int idx, input logic [31:0] d, input logic f, input logic l);
    int g;
    g = 0;
    in_data[idx] = d; in_first[idx] = f; in_last[idx] = l; in_valid[idx] = 1'b1;
    while (!in_ready[idx] && g < 400) begin
      @(posedge clk); #1; g++;
    end
    check("accept", idx, {31'h0, in_ready[idx]}, 32'h1);
    if (in_ready[idx]) begin
      @(posedge clk); #1;
    end
    in_valid[idx] = 1'b0; in_first[idx] = 1'b0; in_last[idx] = 1'b0;
  endtask

  task automatic send_msg(input int idx, input logic [7:0] b [$], input logic use_first);
    foreach (b[i]) send_beat(idx, {24'h0, b[i]}, use_first && (i == 0), i == b.size() - 1);
  endtask

  task automatic drain(input int idx);
    int g;
    g = 0;
    while (exp_q[idx].size() != 0 && g < 500) begin
      @(posedge clk); #1; g++;
    end
    check("drain", idx, exp_q[idx].size(), 32'h0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  s9 [$];
    logic [7:0]  q4 [$];
    logic [7:0]  qa [$];
    logic [7:0]  qb [$];
    logic [31:0] m4 [64];
    logic [31:0] x, e4, ea;
    int          lat, g;
    int          exp_lat [6];

    s9 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    clr = '0; in_valid = '0; in_first = '0; in_last = '0; crc_ready = '1;
    for (int i = 0; i < 6; i++) in_data[i] = 32'h0;
    fork monitor(); join_none

    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 6; i++) begin
      check("rst_crc_valid", i, {31'h0, crc_valid[i]}, 32'h0);
      check("rst_in_ready", i, {31'h0, in_ready[i]}, 32'h1);
      check("rst_busy", i, {31'h0, busy[i]}, 32'h0);
      check("rst_crc_out", i, crc_o[i], 32'h0);
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // CRC-32 check string, busy while the message is open
    exp_q[0].push_back(32'hCBF43926);
    foreach (s9[i]) begin
      send_beat(0, {24'h0, s9[i]}, i == 0, i == 8);
      if (i == 0) check("busy_mid", 0, {31'h0, busy[0]}, 32'h1);
    end
    drain(0);
    check("busy_after", 0, {31'h0, busy[0]}, 32'h0);

    exp_q[1].push_back(32'h0376E6E7);
    send_msg(1, s9, 1'b1);
    drain(1);
    exp_q[2].push_back(32'h000029B1);
    send_msg(2, s9, 1'b1);
    drain(2);

    // identical 64-beat message at 1/8/32 bits per clock
    x = 32'h1234ABCD;
    q4 = {};
    for (int j = 0; j < 64; j++) begin
      x = x * 32'd1103515245 + 32'd12345;
      m4[j] = x;
      for (int b = 0; b < 4; b++) q4.push_back(x[8*b +: 8]);
    end
    e4 = crc32_ref(q4);
    exp_lat[3] = 32; exp_lat[4] = 4; exp_lat[5] = 1;
    for (int idx = 3; idx < 6; idx++) begin
      exp_q[idx].push_back(e4);
      for (int j = 0; j < 64; j++) begin
        send_beat(idx, m4[j], j == 0, j == 63);
        if (j == 0) begin
          lat = 0;
          while (!in_ready[idx] && lat < 100) begin
            @(posedge clk); #1; lat++;
          end
          check("latency", idx, lat, exp_lat[idx]);
        end
      end
      drain(idx);
    end

    // result held under back-pressure; pending beat waits for the handshake
    qa = '{8'h41};
    qb = '{8'h42};
    ea = crc32_ref(qa);
    exp_q[0].push_back(ea);
    exp_q[0].push_back(crc32_ref(qb));
    crc_ready[0] = 1'b0;
    send_beat(0, 32'h41, 1'b1, 1'b1);
    g = 0;
    while (!crc_valid[0] && g < 50) begin
      @(posedge clk); #1; g++;
    end
    in_data[0] = 32'h42; in_first[0] = 1'b1; in_last[0] = 1'b1; in_valid[0] = 1'b1;
    for (int c = 0; c < 20; c++) begin
      check("hold_valid", 0, {31'h0, crc_valid[0]}, 32'h1);
      check("hold_crc", 0, crc_o[0], ea);
      check("hold_in_ready", 0, {31'h0, in_ready[0]}, 32'h0);
      @(posedge clk); #1;
    end
    crc_ready[0] = 1'b1;
    send_beat(0, 32'h42, 1'b1, 1'b1);
    drain(0);

    // clr during SHIFT, then a message without in_first starts from INIT
    send_beat(0, 32'h61, 1'b1, 1'b0);
    check("busy_shift", 0, {31'h0, busy[0]}, 32'h1);
    clr[0] = 1'b1;
    @(posedge clk); #1;
    clr[0] = 1'b0;
    check("clr_valid", 0, {31'h0, crc_valid[0]}, 32'h0);
    check("clr_busy", 0, {31'h0, busy[0]}, 32'h0);
    check("clr_in_ready", 0, {31'h0, in_ready[0]}, 32'h1);
    exp_q[0].push_back(32'hCBF43926);
    send_msg(0, s9, 1'b0);
    drain(0);

    // reset in the middle of a message
    send_beat(0, 32'h62, 1'b1, 1'b0);
    send_beat(0, 32'h63, 1'b0, 1'b0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_mid_valid", 0, {31'h0, crc_valid[0]}, 32'h0);
    check("rst_mid_busy", 0, {31'h0, busy[0]}, 32'h0);
    rst = 1'b1;
    @(posedge clk); #1;

    // in_first mid-message discards the partial CRC
    send_beat(0, 32'h78, 1'b1, 1'b0);
    send_beat(0, 32'h79, 1'b0, 1'b0);
    exp_q[0].push_back(32'hCBF43926);
    send_msg(0, s9, 1'b1);
    drain(0);
    repeat (10) @(posedge clk);
    #1;
    for (int i = 0; i < 6; i++) check("no_valid_end", i, {31'h0, crc_valid[i]}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
